// File: rtl/wr_mem.sv
// Line writer: drains 128-bit FWFT pixel words into memory-controller write bursts,
// double-buffered by frame so the reader always fetches the opposite frame.
module wr_mem #(
   parameter int DWIDTH   = 128,
   parameter int BRST_LEN = 45,
   parameter int BRST_NUM = 4,
   parameter int DEPTH    = 900
) (
   input  logic                memclk,
   input  logic                mem_rst_n,
   input  logic                frame_start,
   input  logic                memcon_en,
   output logic                memcon_donep,
   input  logic [1:0]          arb_state,
   input  logic                src_empty,
   input  logic [DWIDTH-1:0]   src_data,
   output logic                src_rd_en,
   output logic                mcb_wr_en,
   output logic [DWIDTH-1:0]   mcb_wr_data,
   output logic [DWIDTH/8-1:0] mcb_wr_mask,
   input  logic                mcb_wr_full,
   input  logic [6:0]          mcb_wr_count,
   output logic                mcb_cmd_en,
   output logic [2:0]          mcb_cmd_instr,
   output logic [5:0]          mcb_cmd_bl,
   output logic [29:0]         mcb_cmd_byte_addr,
   input  logic                mcb_cmd_full,
   output logic                wr_frame,
   output logic                busy
);

   localparam int BW = (BRST_NUM > 1) ? $clog2(BRST_NUM) : 1;
   localparam logic [BW-1:0] BLAST = BW'(BRST_NUM - 1);
   localparam logic [6:0]    CLAST = 7'(BRST_LEN - 1);
   localparam logic [10:0]   LLAST = 11'(DEPTH - 1);
   localparam logic [12:0]   CSTEP = 13'(BRST_LEN * 16);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      CMD,
      NEXT
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  cntr_q, cntr_d;
   logic [12:0] col_q, col_d;
   logic [BW-1:0] brst_q, brst_d;
   logic [10:0] line_q, line_d;
   logic        pend_q, pend_d;
   logic [3:0]  done_q, done_d;
   logic        frame_q, frame_d;
   logic [29:0] addr_q, addr_d;
   logic        push;
   logic        cmd_go;
   logic        fs_now;
   logic        unused;

   // Occupancy is informational only; the full flag alone gates pushes.
   assign unused = ^mcb_wr_count;

   assign push = (state_q == FILL) && !src_empty && !mcb_wr_full;
   assign cmd_go = (state_q == CMD) && (arb_state == 2'b01)
                   && !mcb_cmd_full;
   assign fs_now = frame_start | pend_q;

   assign src_rd_en         = push;
   assign mcb_wr_en         = push;
   assign mcb_wr_data       = src_data;
   assign mcb_wr_mask       = '0;
   assign mcb_cmd_en        = cmd_go;
   assign mcb_cmd_instr     = 3'b000;
   assign mcb_cmd_bl        = 6'(BRST_LEN - 1);
   assign mcb_cmd_byte_addr = addr_q;
   assign memcon_donep      = |done_q;
   assign wr_frame          = frame_q;
   assign busy              = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cntr_d  = cntr_q;
      col_d   = col_q;
      brst_d  = brst_q;
      line_d  = line_q;
      pend_d  = pend_q | frame_start;
      done_d  = {done_q[2:0], 1'b0};
      frame_d = frame_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            // A clean wrap already left linecnt at 0: no second toggle.
            if (fs_now) begin
               line_d = '0;
               col_d  = '0;
               if (line_q != '0) frame_d = ~frame_q;
            end
            if (memcon_en && !memcon_donep) state_d = FILL;
         end
         FILL: begin
            if (push) begin
               if (cntr_q == CLAST) begin
                  cntr_d  = '0;
                  addr_d  = {5'd0, frame_q, line_q, col_q};
                  state_d = CMD;
               end else begin
                  cntr_d = cntr_q + 7'd1;
               end
            end
         end
         CMD: begin
            if (cmd_go) state_d = NEXT;
         end
         NEXT: begin
            if (brst_q == BLAST) begin
               brst_d    = '0;
               col_d     = '0;
               done_d[0] = 1'b1;
               state_d   = IDLE;
               if (line_q == LLAST) begin
                  line_d  = '0;
                  frame_d = ~frame_q;
               end else begin
                  line_d = line_q + 11'd1;
               end
            end else begin
               brst_d  = brst_q + 1'b1;
               col_d   = col_q + CSTEP;
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge memclk or negedge mem_rst_n) begin
      if (!mem_rst_n) begin
         state_q <= IDLE;
         cntr_q  <= '0;
         col_q   <= '0;
         brst_q  <= '0;
         line_q  <= '0;
         pend_q  <= 1'b0;
         done_q  <= '0;
         frame_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         col_q   <= col_d;
         brst_q  <= brst_d;
         line_q  <= line_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         frame_q <= frame_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: doc/wr_mem.md
Name: wr_mem

Overview:
- Writer-side counterpart of the line-read path. Drains one video line at a time from an upstream first-word-fall-through (FWFT) pixel FIFO of 128-bit words (8 RGB565 pixels each) into the memory controller write port.
- Issues WRITE commands per burst into a double-buffered frame region, so the read side always fetches the opposite frame.
- Sits in the memclk domain, behind the pclk-to-memclk packing FIFO, under the same arbiter handshake (memcon_en / memcon_donep / arb_state).

Parameters:
- DWIDTH, 128, data word width in bits; the mask width is DWIDTH/8.
- BRST_LEN, 45, words per burst; legal range 1..64.
- BRST_NUM, 4, bursts per line. BRST_LEN*BRST_NUM*16 must not exceed 8191.
- DEPTH, 900, lines per frame.

Ports:
- memclk  in  1  sole clock
- mem_rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse (memclk domain), start of the incoming frame
- memcon_en  in  1  arbiter grants a line slot
- memcon_donep  out  1  line-done indication to the arbiter
- arb_state  in  2  arbiter phase; write port owns the bus when 2'b01
- src_empty  in  1  upstream FIFO empty
- src_data  in  DWIDTH  upstream FWFT data
- src_rd_en  out  1  upstream pop
- mcb_wr_en  out  1  memory write-data push
- mcb_wr_data  out  DWIDTH  write data
- mcb_wr_mask  out  DWIDTH/8  byte mask, constant 0
- mcb_wr_full  in  1  write-data FIFO full
- mcb_wr_count  in  7  write-data FIFO occupancy
- mcb_cmd_en  out  1  command strobe
- mcb_cmd_instr  out  3  constant 3'b000 (WRITE)
- mcb_cmd_bl  out  6  BRST_LEN-1
- mcb_cmd_byte_addr  out  30  burst byte address
- mcb_cmd_full  in  1  command FIFO full
- wr_frame  out  1  frame buffer currently being written
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, mem_rst_n low) clears all state:
  - state = IDLE; cntr, col, brstcnt, linecnt, pend_fs, done shift register all 0; wr_frame = 0.
  - mcb_cmd_en, src_rd_en, mcb_wr_en, memcon_donep, busy all 0.
  - Reset mid-burst abandons the burst; no command is issued.
- Data path:
  - src_rd_en = mcb_wr_en = (state==FILL) && ~src_empty && ~mcb_wr_full.
  - mcb_wr_data = src_data, passed combinationally with zero latency.
  - cntr increments on each push.
- Address:
  - mcb_cmd_byte_addr = {5'd0, wr_frame, linecnt[10:0], col[12:0]}, registered when entering CMD.
  - col advances by BRST_LEN*16 after each issued command and returns to 0 at line end.
- States:
  - IDLE: apply any pending frame_start (see boundaries). Move to FILL when memcon_en=1 and memcon_donep=0.
  - FILL: on the push that makes cntr==BRST_LEN, clear cntr and move to CMD.
  - CMD: wait until arb_state==2'b01 and ~mcb_cmd_full, then assert mcb_cmd_en for exactly one cycle and move to NEXT. mcb_cmd_en never asserts in any other state.
  - NEXT:
    - Increment brstcnt and col.
    - If brstcnt==BRST_NUM-1: brstcnt=0, col=0, line advance, done[0]=1, go to IDLE.
    - Otherwise go to FILL.
- Line advance:
  - If linecnt==DEPTH-1: linecnt=0 and wr_frame toggles.
  - Else linecnt+1.
- memcon_donep = OR of the 4-bit done shift register (shifts every cycle). It stays high for 4 cycles, which blocks IDLE re-entry to FILL during that window.
- Boundaries:
  - frame_start arriving while busy sets pend_fs; it is applied on the next IDLE cycle.
  - Applying frame_start: linecnt=0, col=0. wr_frame toggles only if linecnt!=0 at that moment; if it was already 0 (clean wrap), no extra toggle.
  - frame_start coincident with a line-advance wrap: the wrap wins, and the pending start then sees linecnt=0, so there is no double toggle.
  - src_empty or mcb_wr_full stall FILL indefinitely with no pushes; cntr holds.
  - mcb_wr_count is unused for control. It exists for visibility and must never make push and full coincide.

Test Plan:
- Reset, then memcon_en=1, src always non-empty, arb_state=01 -> 4 commands with addr 0, 720, 1440, 2160; bl=44; instr=0; 45 pushes before each command; memcon_donep high 4 cycles; linecnt=1.
- Toggle src_empty every 3 cycles during FILL -> push count per burst is still exactly 45; data order is preserved word-for-word.
- Hold arb_state=00 for 20 cycles in CMD, with mcb_cmd_full high for 5 further cycles -> a single mcb_cmd_en pulse, only after both conditions clear.
- Run 900 lines -> line 899 uses addr {0,0,899,col}; the next line uses wr_frame=1, addr bit 24 set, linecnt 0; a frame_start after the wrap causes no extra toggle.
- frame_start pulse at line 300 mid-burst -> current line completes at linecnt 300; next line starts at linecnt 0, col 0, wr_frame toggled.
- Assert mem_rst_n low mid-FILL (cntr=20) -> all outputs 0 immediately; no cmd_en; restart writes addr 0 frame 0.
